seq_bit_serializer: RTL and testbench

- Upstream stage for the serial sequence detectors. Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on a registered serial line (dout/dout_valid).
- The detector's din connects to dout.
- The serial line idles at 0 so no spurious patterns reach the detector between words.
- Supports back-to-back streaming with no bubble, plus a programmable idle gap between words.

---
 rtl/seq_bit_serializer.sv | 188 ++++++++++++++++++
 tb/tb_seq_bit_serializer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel-to-serial front end for the serial sequence
// detectors. Words arrive over a valid/ready handshake and leave one bit per
// clock on a registered line (dout/dout_valid) that idles at 0.
//
// Handshake: a word is taken at a rising clk edge where load_valid and
// load_ready are both 1; data_in is sampled only at that edge. load_ready is
// a pure function of the current state, never of load_valid.
//
// Optional feature: define SEQ_SER_PARITY_EN to append one even-parity bit
// (XOR of the captured word) after the data bits of every word.
module seq_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0]    GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
`ifdef SEQ_SER_PARITY_EN
        , ST_PAR = 2'd3
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  shift_q, shift_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
    logic              dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              done_q, done_d;
`ifdef SEQ_SER_PARITY_EN
    logic              par_q, par_d;
`endif

    logic accept;

    assign accept     = load_valid && load_ready;
    assign busy       = (state_q != ST_IDLE);
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign done       = done_q;

    // Readiness: always in IDLE, and in the final serial cycle of a word when
    // there is no idle gap so the next word can follow without a bubble.
    always_comb begin
        load_ready = 1'b0;
        case (state_q)
            ST_IDLE:  load_ready = 1'b1;
`ifdef SEQ_SER_PARITY_EN
            ST_PAR:   load_ready = (GAP == 0);
`else
            ST_SHIFT: load_ready = (GAP == 0) && (cnt_q == CNT_LAST);
`endif
            default:  load_ready = 1'b0;
        endcase
    end

    // Next-state, datapath and registered-output values.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        gap_cnt_d = gap_cnt_q;
`ifdef SEQ_SER_PARITY_EN
        par_d     = par_q;
`endif
        if (accept) begin
            // Capture from IDLE or as a bubble-free back-to-back reload.
            state_d = ST_SHIFT;
            shift_d = data_in;
            cnt_d   = '0;
`ifdef SEQ_SER_PARITY_EN
            par_d   = ^data_in;
`endif
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    if (cnt_q != CNT_LAST) begin
                        cnt_d   = cnt_q + 1'b1;
                        shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                            : {1'b0, shift_q[WIDTH-1:1]};
                    end else begin
`ifdef SEQ_SER_PARITY_EN
                        state_d = ST_PAR;
`else
                        if (GAP > 0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
`endif
                    end
                end
`ifdef SEQ_SER_PARITY_EN
                ST_PAR: begin
                    if (GAP > 0) begin
                        state_d   = ST_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
`endif
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Serial line values for the next cycle; dout is forced low when not valid.
    always_comb begin
        dout_d       = 1'b0;
        dout_valid_d = 1'b0;
        done_d       = 1'b0;
        case (state_d)
            ST_SHIFT: begin
                dout_valid_d = 1'b1;
                dout_d       = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
`ifndef SEQ_SER_PARITY_EN
                done_d       = (cnt_d == CNT_LAST);
`endif
            end
`ifdef SEQ_SER_PARITY_EN
            ST_PAR: begin
                dout_valid_d = 1'b1;
                dout_d       = par_d;
                done_d       = 1'b1;
            end
`endif
            default: begin
                dout_d       = 1'b0;
                dout_valid_d = 1'b0;
                done_d       = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            gap_cnt_q    <= '0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            done_q       <= 1'b0;
`ifdef SEQ_SER_PARITY_EN
            par_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            done_q       <= done_d;
`ifdef SEQ_SER_PARITY_EN
            par_q        <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Testbench for seq_bit_serializer: one instance with default parameters and
// one with GAP=2, LSB-first. Outputs are sampled 1 time unit after each
// rising edge and packed as {dout, dout_valid, done, load_ready, busy}.
module tb_seq_bit_serializer;

`ifdef SEQ_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in, data_in_g;
    logic       load_valid, load_valid_g;
    logic       load_ready, dout, dout_valid, busy, done;
    logic       load_ready_g, dout_g, dout_valid_g, busy_g, done_g;
    logic [4:0] obs_a, obs_g;

    int n_checks = 0;
    int n_fail   = 0;

    assign obs_a = {dout, dout_valid, done, load_ready, busy};
    assign obs_g = {dout_g, dout_valid_g, done_g, load_ready_g, busy_g};

    seq_bit_serializer dut (
        .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
        .load_ready(load_ready), .dout(dout), .dout_valid(dout_valid),
        .busy(busy), .done(done)
    );

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP(2)) dut_g (
        .clk(clk), .rst(rst), .data_in(data_in_g), .load_valid(load_valid_g),
        .load_ready(load_ready_g), .dout(dout_g), .dout_valid(dout_valid_g),
        .busy(busy_g), .done(done_g)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; load_valid = 1'b0; load_valid_g = 1'b0;
        data_in = 8'h00; data_in_g = 8'h00;
        repeat (3) tick();
        n_checks++;
        if (obs_a !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset_a: got %b expected %b", obs_a, 5'b00010);
        end
        n_checks++;
        if (obs_g !== 5'b00010) begin
            n_fail++;
            $display("FAIL reset_g: got %b expected %b", obs_g, 5'b00010);
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (obs_a !== 5'b00010 || obs_g !== 5'b00010) begin
                n_fail++;
                $display("FAIL idle cycle %0d: got %b/%b expected 00010", i, obs_a, obs_g);
            end
        end
    endtask

    task automatic test_single_word();
        logic [7:0] w;
        logic [4:0] exp;
        w = 8'hA0;  // bits 1,0,1,0,0,0,0,0 MSB first
        data_in = w; load_valid = 1'b1;
        tick();
        load_valid = 1'b0; data_in = 8'h00;
        for (int c = 1; c <= 8; c++) begin
            exp = {w[8-c], 1'b1, (c == 8 && PAR == 0), (c == 8 && PAR == 0), 1'b1};
            n_checks++;
            if (obs_a !== exp) begin
                n_fail++;
                $display("FAIL single cycle %0d: got %b expected %b", c, obs_a, exp);
            end
            tick();
        end
        if (PAR == 1) begin
            exp = {^w, 1'b1, 1'b1, 1'b1, 1'b1};
            n_checks++;
            if (obs_a !== exp) begin
                n_fail++;
                $display("FAIL single parity: got %b expected %b", obs_a, exp);
            end
            tick();
        end
        n_checks++;
        if (obs_a !== 5'b00010) begin
            n_fail++;
            $display("FAIL single idle: got %b expected %b", obs_a, 5'b00010);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w0, w1, word;
        logic [4:0] exp;
        int         p, k;
        p  = 8 + PAR;
        w0 = 8'h05;  // 00000101
        w1 = 8'hC3;  // 11000011
        data_in = w0; load_valid = 1'b1;
        tick();
        data_in = w1;  // held with load_valid high; only the ready cycle takes it
        for (int c = 1; c <= 2 * p; c++) begin
            word = (c <= p) ? w0 : w1;
            k    = (c <= p) ? c : c - p;
            exp  = {((k <= 8) ? word[8-k] : ^word), 1'b1, (k == p), (k == p), 1'b1};
            n_checks++;
            if (obs_a !== exp) begin
                n_fail++;
                $display("FAIL b2b cycle %0d: got %b expected %b", c, obs_a, exp);
            end
            tick();
            if (c == p) load_valid = 1'b0;
        end
        n_checks++;
        if (obs_a !== 5'b00010) begin
            n_fail++;
            $display("FAIL b2b idle: got %b expected %b", obs_a, 5'b00010);
        end
    endtask

    task automatic test_gap_lsb_first();
        logic [7:0] w;
        logic [4:0] exp;
        w = 8'h01;  // bits 1,0,0,0,0,0,0,0 LSB first
        data_in_g = w; load_valid_g = 1'b1;
        tick();
        load_valid_g = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            exp = {w[c-1], 1'b1, (c == 8 && PAR == 0), 1'b0, 1'b1};
            n_checks++;
            if (obs_g !== exp) begin
                n_fail++;
                $display("FAIL gap_word cycle %0d: got %b expected %b", c, obs_g, exp);
            end
            tick();
        end
        if (PAR == 1) begin
            exp = {^w, 1'b1, 1'b1, 1'b0, 1'b1};
            n_checks++;
            if (obs_g !== exp) begin
                n_fail++;
                $display("FAIL gap_parity: got %b expected %b", obs_g, exp);
            end
            tick();
        end
        for (int g = 1; g <= 2; g++) begin
            n_checks++;
            if (obs_g !== 5'b00001) begin
                n_fail++;
                $display("FAIL gap cycle %0d: got %b expected %b", g, obs_g, 5'b00001);
            end
            tick();
        end
        n_checks++;
        if (obs_g !== 5'b00010) begin
            n_fail++;
            $display("FAIL gap_end: got %b expected %b", obs_g, 5'b00010);
        end
    endtask

    task automatic test_mid_reset();
        data_in = 8'hFF; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if (obs_a !== 5'b11001) begin
                n_fail++;
                $display("FAIL midrst cycle %0d: got %b expected %b", c, obs_a, 5'b11001);
            end
            if (c == 4) rst = 1'b0;
            tick();
        end
        n_checks++;
        if (obs_a !== 5'b00010) begin
            n_fail++;
            $display("FAIL midrst reset: got %b expected %b", obs_a, 5'b00010);
        end
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (obs_a !== 5'b00010) begin
                n_fail++;
                $display("FAIL midrst after %0d: got %b expected %b", i, obs_a, 5'b00010);
            end
        end
    endtask

`ifdef SEQ_SER_PARITY_EN
    task automatic test_parity();
        logic [7:0] w;
        logic [4:0] exp;
        w = 8'h07;  // bits 0,0,0,0,0,1,1,1 then parity 1
        data_in = w; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            exp = {w[8-c], 1'b1, 1'b0, 1'b0, 1'b1};
            n_checks++;
            if (obs_a !== exp) begin
                n_fail++;
                $display("FAIL parity_data cycle %0d: got %b expected %b", c, obs_a, exp);
            end
            tick();
        end
        n_checks++;
        if (obs_a !== 5'b11111) begin
            n_fail++;
            $display("FAIL parity_bit: got %b expected %b", obs_a, 5'b11111);
        end
        tick();
        n_checks++;
        if (obs_a !== 5'b00010) begin
            n_fail++;
            $display("FAIL parity_idle: got %b expected %b", obs_a, 5'b00010);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_gap_lsb_first();
        test_mid_reset();
`ifdef SEQ_SER_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
